// File: rtl/nios2_soc_cpu_jtag_debug_scan_driver_if.sv
// ---------------------------------------------------------------------------
// nios2_soc_cpu_jtag_debug_scan_driver_if
//
// Command/response bundle between a host and the virtual-JTAG scan driver.
//
// Handshake: each channel transfers on a clk edge where valid && ready.
//   The source holds valid and its payload steady until that edge and never
//   withdraws it early. The sink may raise or lower ready at any time.
//   cmd: host -> driver  (cmd_valid, cmd_ir, cmd_dr / cmd_ready)
//   rsp: driver -> host  (rsp_valid, rsp_dr       / rsp_ready)
//
// Modports:
//   master - the host issuing scan commands
//   slave  - the scan driver
// ---------------------------------------------------------------------------
interface nios2_soc_cpu_jtag_debug_scan_driver_if #(
    parameter int IR_WIDTH = 2,
    parameter int DR_WIDTH = 38
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dr
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dr
    );
endinterface

// File: rtl/nios2_soc_cpu_jtag_debug_scan_driver.sv
// ---------------------------------------------------------------------------
// nios2_soc_cpu_jtag_debug_scan_driver
//
// Host-side driver for the CPU's virtual-JTAG debug port. Takes one scan
// command (IR value + DR word), walks UIR -> CDR -> SDR x DR_WIDTH -> UDR ->
// RTI x RTI_TCKS with a generated tck, and returns the shifted-out DR word.
// Replaces the hard SLD hub for on-chip self-test and simulation.
//
// Each state lasts whole tck slots (2*TCK_HALF clk, tck low then high).
// Strobes and tdi launch on the clk edge that makes tck fall (or on slot
// entry from IDLE); tdo is sampled on the clk edge that makes tck rise.
//
// Optional feature: define NIOS2_SOC_JTAG_SCAN_IR_SKIP_EN to skip the UIR
// slot when the requested IR already sits on vji_ir_in and at least one scan
// has completed since reset.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   bus          slave side of the command/response interface
//   vji_tck      generated test clock
//   vji_tdi      serial data to target (shift[0] during SDR, else 0)
//   vji_tdo      serial data from target
//   vji_ir_in    virtual IR, held between scans
//   vji_cdr/sdr/udr/uir/rti  one-hot virtual TAP state strobes
//   dbg_state    current FSM state encoding
// ---------------------------------------------------------------------------
module nios2_soc_cpu_jtag_debug_scan_driver #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_HALF = 2,
    parameter int RTI_TCKS = 1
) (
    input  logic                clk,
    input  logic                reset,
    nios2_soc_cpu_jtag_debug_scan_driver_if.slave bus,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_uir,
    output logic                vji_rti,
    output logic [2:0]          dbg_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UIR  = 3'd1;
    localparam logic [2:0] S_CDR  = 3'd2;
    localparam logic [2:0] S_SDR  = 3'd3;
    localparam logic [2:0] S_UDR  = 3'd4;
    localparam logic [2:0] S_RTI  = 3'd5;
    localparam logic [2:0] S_RSP  = 3'd6;

`ifdef NIOS2_SOC_JTAG_SCAN_IR_SKIP_EN
    localparam bit IR_SKIP = 1'b1;
`else
    localparam bit IR_SKIP = 1'b0;
`endif

    localparam int HP_W     = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
    localparam int SLOT_MAX = (DR_WIDTH > RTI_TCKS) ? DR_WIDTH : RTI_TCKS;
    localparam int SC_W     = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;

    localparam logic [HP_W-1:0] HP_LAST  = HP_W'(TCK_HALF - 1);
    localparam logic [SC_W-1:0] SDR_LAST = SC_W'(DR_WIDTH - 1);
    localparam logic [SC_W-1:0] RTI_LAST = SC_W'(RTI_TCKS - 1);

    logic [2:0]          state;
    logic [HP_W-1:0]     hp_cnt;
    logic [SC_W-1:0]     slot_cnt;
    logic [DR_WIDTH-1:0] shift_q;
    logic                ir_seen;     // a scan has completed since reset
    logic                cmd_ready_q;
    logic                rsp_valid_q;

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    // tdo bits enter at the MSB, so once SDR finishes the register holds the
    // captured word with the first sampled bit at bit 0.
    assign bus.rsp_dr    = shift_q;
    assign dbg_state     = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            hp_cnt      <= '0;
            slot_cnt    <= '0;
            shift_q     <= '0;
            ir_seen     <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            vji_tck     <= 1'b0;
            vji_tdi     <= 1'b0;
            vji_ir_in   <= '0;
            vji_cdr     <= 1'b0;
            vji_sdr     <= 1'b0;
            vji_udr     <= 1'b0;
            vji_uir     <= 1'b0;
            vji_rti     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        shift_q     <= bus.cmd_dr;
                        hp_cnt      <= '0;
                        slot_cnt    <= '0;
                        vji_tck     <= 1'b0;
                        if (IR_SKIP && ir_seen && (bus.cmd_ir == vji_ir_in)) begin
                            state   <= S_CDR;
                            vji_cdr <= 1'b1;
                        end else begin
                            state     <= S_UIR;
                            vji_uir   <= 1'b1;
                            vji_ir_in <= bus.cmd_ir;
                        end
                    end
                end

                // One idle clk after the last tck fall, then the response is
                // offered and held until the host takes it.
                S_RSP: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= S_IDLE;
                    end
                end

                // Active scan states: tck runs and every transition happens on
                // the falling tck edge that closes a slot.
                default: begin
                    if (hp_cnt == HP_LAST) begin
                        hp_cnt  <= '0;
                        vji_tck <= ~vji_tck;
                        if (!vji_tck) begin
                            if (state == S_SDR) begin
                                shift_q <= {vji_tdo, shift_q[DR_WIDTH-1:1]};
                            end
                        end else begin
                            case (state)
                                S_UIR: begin
                                    state   <= S_CDR;
                                    vji_uir <= 1'b0;
                                    vji_cdr <= 1'b1;
                                end
                                S_CDR: begin
                                    state    <= S_SDR;
                                    vji_cdr  <= 1'b0;
                                    vji_sdr  <= 1'b1;
                                    vji_tdi  <= shift_q[0];
                                    slot_cnt <= '0;
                                end
                                S_SDR: begin
                                    if (slot_cnt == SDR_LAST) begin
                                        state   <= S_UDR;
                                        vji_sdr <= 1'b0;
                                        vji_udr <= 1'b1;
                                        vji_tdi <= 1'b0;
                                    end else begin
                                        slot_cnt <= slot_cnt + SC_W'(1);
                                        vji_tdi  <= shift_q[0];
                                    end
                                end
                                S_UDR: begin
                                    state    <= S_RTI;
                                    vji_udr  <= 1'b0;
                                    vji_rti  <= 1'b1;
                                    slot_cnt <= '0;
                                end
                                S_RTI: begin
                                    if (slot_cnt == RTI_LAST) begin
                                        state   <= S_RSP;
                                        vji_rti <= 1'b0;
                                        ir_seen <= 1'b1;
                                    end else begin
                                        slot_cnt <= slot_cnt + SC_W'(1);
                                    end
                                end
                                default: begin
                                    // Unused encoding: fall back to idle.
                                    state       <= S_IDLE;
                                    cmd_ready_q <= 1'b1;
                                    vji_uir     <= 1'b0;
                                    vji_cdr     <= 1'b0;
                                    vji_sdr     <= 1'b0;
                                    vji_udr     <= 1'b0;
                                    vji_rti     <= 1'b0;
                                    vji_tdi     <= 1'b0;
                                end
                            endcase
                        end
                    end else begin
                        hp_cnt <= hp_cnt + HP_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_soc_cpu_jtag_debug_scan_driver.sv
module tb_nios2_soc_cpu_jtag_debug_scan_driver;
    localparam int DW = 38;
    localparam int IW = 2;
    // Full scan: UIR + CDR + DW*SDR + UDR + RTI slots, plus one RSP entry clk.
    localparam int LAT_A  = 2*2*(3 + DW + 1) + 1;   // 169
    localparam int LAT_B  = 2*1*(3 + DW + 3) + 1;   // 89
    localparam int SLOT_A = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT A: TCK_HALF=2, RTI_TCKS=1 ----------------
    nios2_soc_cpu_jtag_debug_scan_driver_if #(.IR_WIDTH(IW), .DR_WIDTH(DW)) bus_a ();
    logic          tck_a, tdi_a, tdo_a, cdr_a, sdr_a, udr_a, uir_a, rti_a;
    logic [IW-1:0] ir_a;
    logic [2:0]    st_a;

    nios2_soc_cpu_jtag_debug_scan_driver #(
        .DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_HALF(2), .RTI_TCKS(1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus_a.slave),
        .vji_tck(tck_a), .vji_tdi(tdi_a), .vji_tdo(tdo_a), .vji_ir_in(ir_a),
        .vji_cdr(cdr_a), .vji_sdr(sdr_a), .vji_udr(udr_a), .vji_uir(uir_a),
        .vji_rti(rti_a), .dbg_state(st_a)
    );

    // ---------------- DUT B: TCK_HALF=1, RTI_TCKS=3 ----------------
    nios2_soc_cpu_jtag_debug_scan_driver_if #(.IR_WIDTH(IW), .DR_WIDTH(DW)) bus_b ();
    logic          tck_b, tdi_b, tdo_b, cdr_b, sdr_b, udr_b, uir_b, rti_b;
    logic [IW-1:0] ir_b;
    logic [2:0]    st_b;

    nios2_soc_cpu_jtag_debug_scan_driver #(
        .DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_HALF(1), .RTI_TCKS(3)
    ) dut_fast (
        .clk(clk), .reset(reset), .bus(bus_b.slave),
        .vji_tck(tck_b), .vji_tdi(tdi_b), .vji_tdo(tdo_b), .vji_ir_in(ir_b),
        .vji_cdr(cdr_b), .vji_sdr(sdr_b), .vji_udr(udr_b), .vji_uir(uir_b),
        .vji_rti(rti_b), .dbg_state(st_b)
    );

    // ---------------- loopback targets ----------------
    // A DW-bit shift register per DUT: tdo = bit 0, shifts tdi in at the MSB
    // once per rising tck while in SDR (detected one clk after the rise).
    logic [DW-1:0] tgt_a, tgt_init_a, tgt_b, tgt_init_b;
    logic          tgt_load_a, tgt_load_b, tck_d_a, tck_d_b;
    assign tdo_a = tgt_a[0];
    assign tdo_b = tgt_b[0];

    always @(posedge clk) begin
        if (tgt_load_a) tgt_a <= tgt_init_a;
        else if (sdr_a && tck_a && !tck_d_a) tgt_a <= {tdi_a, tgt_a[DW-1:1]};
        tck_d_a <= tck_a;
        if (tgt_load_b) tgt_b <= tgt_init_b;
        else if (sdr_b && tck_b && !tck_d_b) tgt_b <= {tdi_b, tgt_b[DW-1:1]};
        tck_d_b <= tck_b;
    end

    // ---------------- protocol monitor (negedge sampling) ----------------
    int   c_uir, c_cdr, c_sdr_rise, c_udr, c_rti, c_multi, c_tdi_bad;
    int   c_rti_b, c_rise_b;
    logic p_tck_a, p_tdi_a, p_rst, p_tck_b;

    initial begin
        c_uir = 0; c_cdr = 0; c_sdr_rise = 0; c_udr = 0; c_rti = 0;
        c_multi = 0; c_tdi_bad = 0; c_rti_b = 0; c_rise_b = 0;
        p_tck_a = 1'b0; p_tdi_a = 1'b0; p_rst = 1'b1; p_tck_b = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && !p_rst) begin
                c_uir      += int'(uir_a);
                c_cdr      += int'(cdr_a);
                c_udr      += int'(udr_a);
                c_rti      += int'(rti_a);
                c_sdr_rise += int'(sdr_a && tck_a && !p_tck_a);
                if ((int'(uir_a) + int'(cdr_a) + int'(sdr_a) + int'(udr_a) + int'(rti_a)) > 1)
                    c_multi++;
                if ((int'(uir_b) + int'(cdr_b) + int'(sdr_b) + int'(udr_b) + int'(rti_b)) > 1)
                    c_multi++;
                if (tdi_a !== p_tdi_a && !(p_tck_a && !tck_a)) c_tdi_bad++;
                c_rti_b  += int'(rti_b);
                c_rise_b += int'(tck_b && !p_tck_b);
            end
            p_tck_a = tck_a;
            p_tdi_a = tdi_a;
            p_tck_b = tck_b;
            p_rst   = reset;
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    logic          ir_seen_m = 1'b0;
    logic [IW-1:0] last_ir_m = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_lat_a(input logic [IW-1:0] ir);
`ifdef NIOS2_SOC_JTAG_SCAN_IR_SKIP_EN
        if (ir_seen_m && ir == last_ir_m) return LAT_A - SLOT_A;
`endif
        return LAT_A;
    endfunction

    // ---------------- driver tasks (inputs change at posedge+1) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_tgt_a(input logic [DW-1:0] v);
        tgt_init_a = v;
        tgt_load_a = 1'b1;
        tick();
        tgt_load_a = 1'b0;
    endtask

    task automatic launch_a(input logic [IW-1:0] ir, input logic [DW-1:0] dr);
        int t;
        t = 0;
        while (bus_a.cmd_ready !== 1'b1 && t < 1000) begin tick(); t++; end
        chk("launch_ready", 64'(bus_a.cmd_ready), 64'd1);
        bus_a.cmd_ir    = ir;
        bus_a.cmd_dr    = dr;
        bus_a.cmd_valid = 1'b1;
        tick();
        bus_a.cmd_valid = 1'b0;
    endtask

    // Counts clk edges after the accept edge until rsp_valid is seen.
    task automatic wait_rsp_a(output int lat);
        lat = 0;
        while (bus_a.rsp_valid !== 1'b1 && lat < 2000) begin tick(); lat++; end
        chk("rsp_valid_seen", 64'(bus_a.rsp_valid), 64'd1);
    endtask

    task automatic check_rsp_a();
        logic [DW-1:0] e;
        if (exp_q.size() == 0) e = 'x;
        else e = exp_q.pop_front();
        chk("rsp_dr", 64'(bus_a.rsp_dr), 64'(e));
    endtask

    // Full scan on DUT A with rsp_ready high; checks latency, response,
    // tdi stream seen by the target, and vji_ir_in.
    task automatic scan_a(input logic [IW-1:0] ir, input logic [DW-1:0] dr,
                          input logic [DW-1:0] pre);
        int lat, el;
        el = exp_lat_a(ir);
        load_tgt_a(pre);
        exp_q.push_back(pre);
        launch_a(ir, dr);
        wait_rsp_a(lat);
        chk("latency", 64'(lat), 64'(el));
        check_rsp_a();
        chk("tdi_stream", 64'(tgt_a), 64'(dr));
        chk("ir_in", 64'(ir_a), 64'(ir));
        tick();
        chk("ready_after_rsp", 64'({bus_a.cmd_ready, bus_a.rsp_valid}), 64'b10);
        ir_seen_m = 1'b1;
        last_ir_m = ir;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [IW-1:0] ir;
        logic [DW-1:0] dr;
        logic [DW-1:0] pre;   // target preload = expected rsp_dr
    } vec_t;
    vec_t vt[8];

    initial begin
        int s0[5];
        int s1[5];
        int lat, bad, ub;
        logic [DW-1:0] hold;

        vt[0] = '{2'b01, 38'h2A_5555_AAAA, 38'h15_0F0F_F0F0};
        vt[1] = '{2'b10, 38'h3F_FFFF_FFFF, 38'h00_0000_0000};
        vt[2] = '{2'b11, 38'h00_0000_0001, 38'h20_0000_0000};
        vt[3] = '{2'b00, 38'h12_3456_789A, 38'h3F_FFFF_FFFF};
        for (int i = 4; i < 8; i++) begin
            vt[i].ir  = IW'($urandom_range(0, 3));
            vt[i].dr  = {6'($urandom_range(0, 63)), 32'($urandom)};
            vt[i].pre = {6'($urandom_range(0, 63)), 32'($urandom)};
        end

        reset = 1'b1;
        bus_a.cmd_valid = 1'b0; bus_a.cmd_ir = '0; bus_a.cmd_dr = '0; bus_a.rsp_ready = 1'b1;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_ir = '0; bus_b.cmd_dr = '0; bus_b.rsp_ready = 1'b1;
        tgt_load_a = 1'b0; tgt_load_b = 1'b0; tgt_init_a = '0; tgt_init_b = '0;
        repeat (3) tick();
        reset = 1'b0;

        // reset state
        chk("rst_ready", 64'(bus_a.cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus_a.rsp_valid), 64'd0);
        chk("rst_tck_tdi", 64'({tck_a, tdi_a}), 64'd0);
        chk("rst_strobes", 64'({uir_a, cdr_a, sdr_a, udr_a, rti_a}), 64'd0);
        chk("rst_ir_in", 64'(ir_a), 64'd0);
        chk("rst_state", 64'(st_a), 64'd0);

        // table-driven scans; strobe accounting on the first one
        for (int i = 0; i < 8; i++) begin
            s0 = '{c_uir, c_cdr, c_sdr_rise, c_udr, c_rti};
            scan_a(vt[i].ir, vt[i].dr, vt[i].pre);
            s1 = '{c_uir, c_cdr, c_sdr_rise, c_udr, c_rti};
            if (i == 0) begin
                chk("uir_clks", 64'(s1[0] - s0[0]), 64'(SLOT_A));
                chk("cdr_clks", 64'(s1[1] - s0[1]), 64'(SLOT_A));
                chk("sdr_rises", 64'(s1[2] - s0[2]), 64'(DW));
                chk("udr_clks", 64'(s1[3] - s0[3]), 64'(SLOT_A));
                chk("rti_clks", 64'(s1[4] - s0[4]), 64'(SLOT_A));
            end
        end

        // backpressure: rsp held while rsp_ready low; busy cmd_valid ignored
        bus_a.rsp_ready = 1'b0;
        load_tgt_a(38'h0C_A5A5_1234);
        exp_q.push_back(38'h0C_A5A5_1234);
        launch_a(2'b01, 38'h31_8000_0001);
        wait_rsp_a(lat);
        check_rsp_a();
        hold = bus_a.rsp_dr;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus_a.cmd_valid = (i == 3 || i == 4);
            bus_a.cmd_ir    = 2'b11;
            tick();
            if (bus_a.rsp_valid !== 1'b1 || bus_a.rsp_dr !== hold || bus_a.cmd_ready !== 1'b0)
                bad++;
        end
        bus_a.cmd_valid = 1'b0;
        chk("rsp_hold_stable", 64'(bad), 64'd0);
        bus_a.rsp_ready = 1'b1;
        tick();
        chk("ready_on_rsp_take", 64'({bus_a.cmd_ready, bus_a.rsp_valid}), 64'b10);
        repeat (4) tick();
        chk("busy_cmd_ignored", 64'({st_a, tck_a, ir_a}), 64'({3'd0, 1'b0, 2'b01}));
        ir_seen_m = 1'b1;
        last_ir_m = 2'b01;

        // reset 20 SDR slots into a scan
        load_tgt_a(38'h3F_0000_FFFF);
        launch_a(2'b11, 38'h15_5555_5555);
        repeat (2 * SLOT_A + 20 * SLOT_A) tick();
        chk("mid_scan_in_sdr", 64'(sdr_a), 64'd1);
        reset = 1'b1;
        tick();
        chk("abort_tck", 64'(tck_a), 64'd0);
        chk("abort_strobes", 64'({uir_a, cdr_a, sdr_a, udr_a, rti_a, tdi_a}), 64'd0);
        chk("abort_ir_in", 64'(ir_a), 64'd0);
        chk("abort_handshake", 64'({bus_a.cmd_ready, bus_a.rsp_valid}), 64'b10);
        reset = 1'b0;
        ir_seen_m = 1'b0;
        last_ir_m = '0;
        scan_a(2'b11, 38'h2B_DEAD_BEEF, 38'h06_1357_9BDF);

        // back-to-back with the same IR
        scan_a(2'b10, 38'h11_1111_1111, 38'h22_2222_2222);
        ub = c_uir;
        scan_a(2'b10, 38'h33_3333_3333, 38'h0F_0F0F_0F0F);
`ifdef NIOS2_SOC_JTAG_SCAN_IR_SKIP_EN
        chk("uir_second_scan", 64'(c_uir - ub), 64'd0);
`else
        chk("uir_second_scan", 64'(c_uir - ub), 64'(SLOT_A));
`endif

        // DUT B: TCK_HALF=1, RTI_TCKS=3
        chk("fast_rst_ready", 64'(bus_b.cmd_ready), 64'd1);
        tgt_init_b = 38'h0A_BCDE_F012;
        tgt_load_b = 1'b1;
        tick();
        tgt_load_b = 1'b0;
        s0[0] = c_rti_b;
        s0[1] = c_rise_b;
        bus_b.cmd_ir    = 2'b01;
        bus_b.cmd_dr    = 38'h1C_3C3C_5A5A;
        bus_b.cmd_valid = 1'b1;
        tick();
        bus_b.cmd_valid = 1'b0;
        lat = 0;
        while (bus_b.rsp_valid !== 1'b1 && lat < 2000) begin tick(); lat++; end
        chk("fast_latency", 64'(lat), 64'(LAT_B));
        chk("fast_rsp_dr", 64'(bus_b.rsp_dr), 64'(38'h0A_BCDE_F012));
        chk("fast_tdi_stream", 64'(tgt_b), 64'(38'h1C_3C3C_5A5A));
        chk("fast_rti_clks", 64'(c_rti_b - s0[0]), 64'd6);
        chk("fast_tck_rises", 64'(c_rise_b - s0[1]), 64'(3 + DW + 3));
        tick();
        chk("fast_ready_after", 64'(bus_b.cmd_ready), 64'd1);

        // whole-run protocol checks
        chk("never_two_strobes", 64'(c_multi), 64'd0);
        chk("tdi_only_on_fall", 64'(c_tdi_bad), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, required finish by 2ms");
        $fatal(1);
    end
endmodule

// File: doc/nios2_soc_cpu_jtag_debug_scan_driver.md
Name: nios2_soc_cpu_jtag_debug_scan_driver

Overview:
- Host-side driver for the CPU's virtual-JTAG debug port.
- Generates the signal set that the debug module's TCK-domain logic consumes: tck, tdi, ir_in, virtual CDR/SDR/UDR/UIR and RTI state strobes. Captures tdo.
- Accepts one scan command at a time (IR value plus 38-bit DR word) and returns the shifted-out DR word.
- Drives the debug module directly in on-chip self-test and in simulation, replacing the hard SLD hub.

Parameters:
- DR_WIDTH, 38, shift-register length (matches debug sr width)
- IR_WIDTH, 2, virtual IR width
- TCK_HALF, 2, clk cycles per tck half-period; minimum 1
- RTI_TCKS, 1, tck periods spent in run-test-idle after each scan; minimum 1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  scan command valid
- cmd_ready  out  1  driver idle; accepts command
- cmd_ir  in  IR_WIDTH  IR value for this scan
- cmd_dr  in  DR_WIDTH  DR word to shift in, LSB first
- rsp_valid  out  1  result valid; held until rsp_ready
- rsp_ready  in  1  result consumed
- rsp_dr  out  DR_WIDTH  captured tdo word; first shifted bit at bit 0
- vji_tck  out  1  generated test clock
- vji_tdi  out  1  serial data to target
- vji_tdo  in  1  serial data from target
- vji_ir_in  out  IR_WIDTH  virtual IR; held between scans
- vji_cdr  out  1  capture-DR state
- vji_sdr  out  1  shift-DR state
- vji_udr  out  1  update-DR state
- vji_uir  out  1  update-IR state
- vji_rti  out  1  run-test-idle state

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1. State=IDLE; half-period counter=0.
- tck generation:
  - A half-period counter runs only outside IDLE/RSP.
  - vji_tck toggles when the counter reaches TCK_HALF-1; the counter then returns to 0.
  - One "tck slot" = 2*TCK_HALF clk cycles, beginning with tck low.
  - vji_tck is 0 whenever in IDLE or RSP.
- Launch/sample edges:
  - State strobes and vji_tdi change only on the clk edge that makes tck fall, or on slot entry from IDLE.
  - vji_tdo is sampled on the clk edge that makes tck rise, i.e. the value present just before the rising edge.
- Handshake:
  - Command accepted on a clk edge where cmd_valid && cmd_ready.
  - cmd_ready deasserts on the same edge; cmd_ir/cmd_dr are latched.
- States, one tck slot each unless stated:
  - IDLE: wait for a command.
  - UIR: vji_ir_in <= cmd_ir; vji_uir=1.
  - CDR: vji_cdr=1.
  - SDR: DR_WIDTH slots with vji_sdr=1.
    - vji_tdi = shift[0]; shift right each rising tck.
    - tdo is inserted at the MSB, so after DR_WIDTH slots rsp_dr[0] holds the first sampled bit.
  - UDR: vji_udr=1.
  - RTI: RTI_TCKS slots with vji_rti=1.
  - RSP: rsp_valid=1, rsp_dr stable. Return to IDLE on rsp_valid && rsp_ready, reasserting cmd_ready that edge.
- Exactly one strobe among uir/cdr/sdr/udr/rti is high outside IDLE/RSP. All are low in IDLE/RSP.
- vji_tdi=0 outside SDR.
- vji_ir_in retains the last written IR value through IDLE and later scans; it resets to 0.
- cmd_valid asserted while busy is ignored; there is no queueing.
- Latency from accept to rsp_valid = (3 + DR_WIDTH + RTI_TCKS) * 2*TCK_HALF clk cycles, +1 cycle for RSP entry.
- Reset asserted mid-scan: on the next clk edge all state returns to reset values. No response is produced, tck drops to 0, and vji_ir_in becomes 0.
- rsp_ready held high continuously: RSP lasts exactly one clk cycle.

Optional Feature:
- Macro NIOS2_SOC_JTAG_SCAN_IR_SKIP_EN.
- Defined: if the latched cmd_ir equals the current vji_ir_in and at least one scan has completed since reset, UIR is skipped and the scan starts at CDR. Latency shrinks by one tck slot.
- Undefined: UIR is always executed.

Test Plan:
- Reset, TCK_HALF=2: cmd_ir=2'b01, cmd_dr=38'h2A_5555_AAAA, target tdo tied to a 38-bit loopback shift register preloaded 38'h15_0F0F_F0F0 -> tdi stream equals cmd_dr LSB first; rsp_dr=38'h15_0F0F_F0F0; rsp_valid at cycle 4*(3+38+1)+1=169 after accept.
- Strobe ordering check on the same scan -> uir 1 slot, cdr 1 slot, sdr 38 rising tck edges, udr 1 slot, rti 1 slot; never two strobes high; tdi changes only on falling tck.
- rsp_ready held low 10 cycles -> rsp_valid and rsp_dr stable; cmd_valid pulsed during that window is ignored; cmd_ready rises on the edge where rsp_ready=1.
- Reset asserted 20 SDR slots into a scan -> next edge: tck=0, all strobes 0, ir_in=0, cmd_ready=1, no rsp_valid; a new scan then completes normally.
- Two back-to-back scans with cmd_ir=2'b10 both times -> with NIOS2_SOC_JTAG_SCAN_IR_SKIP_EN, second scan has no uir pulse and is 4 clk shorter; without the macro, uir pulses on both.
- TCK_HALF=1, RTI_TCKS=3 -> tck period 2 clk, rti high 6 clk, total latency 2*(3+38+3)+1=89 clk.
